// File: rtl/note_search_pkg.sv
// Shared types and constants for the frequency -> MIDI note search.
// Holds the FSM state and search-phase encodings and the probe-address helper.
package note_search_pkg;

    localparam int         NOTE_W   = 7;
    localparam logic [6:0] NOTE_MAX = 7'd127;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WT   = 3'd2,
        CMP  = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        FLOOR  = 2'd1,
        UPPER  = 2'd2
    } phase_t;

    // Next ROM address to probe: the result so far with bit b set.
    function automatic logic [6:0] probe_addr(input logic [6:0] res, input logic [2:0] b);
        return res | (7'd1 << b);
    endfunction

endpackage

// File: rtl/note_dist_sel.sv
// Nearest-note chooser: given a frequency bracketed by lo and hi table values,
// says whether the upper note is strictly closer. Equal distances pick the lower
// note. Both differences are non-negative because lo <= freq < hi.
module note_dist_sel #(
    parameter int W = 14
) (
    input  logic [W-1:0] i_freq,
    input  logic [W-1:0] i_lo,
    input  logic [W-1:0] i_hi,
    output logic         o_pick_hi
);

    logic [W-1:0] w_d_lo;
    logic [W-1:0] w_d_hi;

    // Distance of the frequency to each neighbour and the strict-less decision.
    always_comb begin
        w_d_lo    = i_freq - i_lo;
        w_d_hi    = i_hi - i_freq;
        o_pick_hi = (w_d_hi < w_d_lo);
    end

endmodule

// File: rtl/note_freq_search.sv
// note_freq_search: maps a measured frequency (Hz) back to a MIDI note by binary
// search over the ascending note->frequency ROM, whose read port this block owns.
// Seven probes build the largest index whose ROM value is <= freq, then one more
// read of that index produces the exact/under/over flags.
// Optional macro NOTE_NEAREST_EN: adds a read of the next-higher entry and rounds
// to the nearer note (ties go to the lower note). Without it the result is the floor.
module note_freq_search
    import note_search_pkg::*;
#(
    parameter int ROM_LAT = 1,
    parameter int FREQ_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [FREQ_W-1:0] freq_in,
    output logic              busy,
    output logic              done,
    output logic [6:0]        note_out,
    output logic              exact,
    output logic              under,
    output logic              over,
    output logic              rom_ce,
    output logic [6:0]        rom_ad,
    input  logic [FREQ_W-1:0] rom_dout
);

    // Last value of the wait counter; WT lasts ROM_LAT-1 cycles and is skipped at ROM_LAT=1.
    localparam logic [7:0] WT_LAST = 8'((ROM_LAT > 2) ? (ROM_LAT - 2) : 0);

    state_t            r_state;
    state_t            w_state_nx;
    phase_t            r_phase;
    logic [FREQ_W-1:0] r_freq;
    logic [6:0]        r_res;
    logic [2:0]        r_bit;
    logic [7:0]        r_wait;
    logic              r_ex;
    logic              r_un;
    logic              r_ov;

    logic              r_busy;
    logic              r_done;
    logic [6:0]        r_note;
    logic              r_exact;
    logic              r_under;
    logic              r_over;
    logic              r_rom_ce;
    logic [6:0]        r_rom_ad;

    logic [6:0]        w_res_upd;
    logic [6:0]        w_ad_nx;
    logic              w_le;
    logic              w_lt;
    logic              w_eq;
    logic              w_gt;
    logic              w_need_upper;

    assign w_le = (rom_dout <= r_freq);
    assign w_lt = (r_freq < rom_dout);
    assign w_eq = (r_freq == rom_dout);
    assign w_gt = (r_freq > rom_dout);

`ifdef NOTE_NEAREST_EN
    logic [FREQ_W-1:0] r_lo;
    logic              w_pick_hi;

    // Upper neighbour is only worth reading when the floor is neither exact nor below the table.
    assign w_need_upper = (r_res != NOTE_MAX) && !w_lt && !w_eq;

    note_dist_sel #(
        .W(FREQ_W)
    ) u_dist (
        .i_freq   (r_freq),
        .i_lo     (r_lo),
        .i_hi     (rom_dout),
        .o_pick_hi(w_pick_hi)
    );

    // Capture ROM[floor] during the FLOOR compare as the lower bracket value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo <= '0;
        end else if (r_state == CMP && r_phase == FLOOR) begin
            r_lo <= rom_dout;
        end
    end
`else
    assign w_need_upper = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic: one RD/WT/CMP round per ROM read, DONE after the last compare.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nx = RD;
                else       w_state_nx = IDLE;
            end
            RD: begin
                if (ROM_LAT > 1) w_state_nx = WT;
                else             w_state_nx = CMP;
            end
            WT: begin
                if (r_wait == WT_LAST) w_state_nx = CMP;
                else                   w_state_nx = WT;
            end
            CMP: begin
                case (r_phase)
                    SEARCH:  w_state_nx = RD;
                    FLOOR: begin
                        if (w_need_upper) w_state_nx = RD;
                        else              w_state_nx = DONE;
                    end
                    UPPER:   w_state_nx = DONE;
                    default: w_state_nx = DONE;
                endcase
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Result after the current SEARCH compare and the address for the next read.
    always_comb begin
        w_res_upd = r_res;
        w_ad_nx   = r_rom_ad;
        if (r_phase == SEARCH && w_le) w_res_upd = r_rom_ad;
        else                           w_res_upd = r_res;
        case (r_state)
            IDLE: w_ad_nx = probe_addr(7'd0, 3'd6);
            CMP: begin
                if (r_phase == SEARCH) begin
                    if (r_bit == 3'd0) w_ad_nx = w_res_upd;
                    else               w_ad_nx = probe_addr(w_res_upd, r_bit - 3'd1);
                end else begin
                    w_ad_nx = r_res + 7'd1;
                end
            end
            default: w_ad_nx = r_rom_ad;
        endcase
    end

    // Search datapath, ROM port and result registers; results only change on done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= SEARCH;
            r_freq   <= '0;
            r_res    <= 7'd0;
            r_bit    <= 3'd0;
            r_wait   <= 8'd0;
            r_ex     <= 1'b0;
            r_un     <= 1'b0;
            r_ov     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_note   <= 7'd0;
            r_exact  <= 1'b0;
            r_under  <= 1'b0;
            r_over   <= 1'b0;
            r_rom_ce <= 1'b0;
            r_rom_ad <= 7'd0;
        end else begin
            r_rom_ce <= (w_state_nx == RD);
            if (w_state_nx == RD) r_rom_ad <= w_ad_nx;
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_freq  <= freq_in;
                        r_res   <= 7'd0;
                        r_bit   <= 3'd6;
                        r_phase <= SEARCH;
                        r_ex    <= 1'b0;
                        r_un    <= 1'b0;
                        r_ov    <= 1'b0;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                RD: r_wait <= 8'd0;
                WT: r_wait <= r_wait + 8'd1;
                CMP: begin
                    case (r_phase)
                        SEARCH: begin
                            r_res <= w_res_upd;
                            if (r_bit == 3'd0) r_phase <= FLOOR;
                            else               r_bit   <= r_bit - 3'd1;
                        end
                        FLOOR: begin
                            r_un <= w_lt;
                            r_ov <= (r_res == NOTE_MAX) && w_gt;
                            r_ex <= w_eq;
                            if (w_need_upper) r_phase <= UPPER;
                        end
`ifdef NOTE_NEAREST_EN
                        UPPER: begin
                            if (w_pick_hi) r_res <= r_res + 7'd1;
                        end
`endif
                        default: r_phase <= r_phase;
                    endcase
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_note  <= r_res;
                    r_exact <= r_ex;
                    r_under <= r_un;
                    r_over  <= r_ov;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign note_out = r_note;
    assign exact    = r_exact;
    assign under    = r_under;
    assign over     = r_over;
    assign rom_ce   = r_rom_ce;
    assign rom_ad   = r_rom_ad;

endmodule
